// File: rtl/sha256_pkg.sv
// Shared widths and FSM state encoding for the SHA-256 message arbiter.
package sha256_pkg;

   localparam int SHA256_BLOCK_W  = 512;
   localparam int SHA256_DIGEST_W = 256;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_NEXT  = 3'd3,
      ST_DONE  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sha256_msg_arbiter_if.sv
// Requester, core and digest signals between the arbiter and its environment.
interface sha256_msg_arbiter_if
   import sha256_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
);

   logic [N_REQ-1:0]                req_valid;
   logic [N_REQ*SHA256_BLOCK_W-1:0] req_block;
   logic [N_REQ-1:0]                req_first;
   logic [N_REQ-1:0]                req_last;
   logic [N_REQ-1:0]                req_ready;

   logic                            core_start;
   logic                            core_init;
   logic [SHA256_BLOCK_W-1:0]       core_block;
   logic                            core_ready;
   logic                            core_hash_valid;
   logic [SHA256_DIGEST_W-1:0]      core_hash;

   logic [SHA256_DIGEST_W-1:0]      digest_out;
   logic                            digest_valid;
   logic [ID_W-1:0]                 digest_id;
   logic                            proto_err;
   logic                            busy;

   // Arbiter side.
   modport slave (
      input  req_valid, req_block, req_first, req_last,
      input  core_ready, core_hash_valid, core_hash,
      output req_ready, core_start, core_init, core_block,
      output digest_out, digest_valid, digest_id, proto_err, busy
   );

   // Requesters plus core, seen from outside the arbiter.
   modport master (
      output req_valid, req_block, req_first, req_last,
      output core_ready, core_hash_valid, core_hash,
      input  req_ready, core_start, core_init, core_block,
      input  digest_out, digest_valid, digest_id, proto_err, busy
   );

endinterface

// File: rtl/sha256_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping.
module sha256_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = IDX_W'((int'(ptr) + k) % N);
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/sha256_msg_arbiter.sv
// Shares one SHA-256 core between N_REQ requesters, one whole message per grant,
// chaining blocks through the core and returning the final digest with its owner id.
module sha256_msg_arbiter
   import sha256_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input logic                 clk,
   input logic                 reset,
   sha256_msg_arbiter_if.slave bus
);

   arb_state_t                 state_q, state_d;
   logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]            owner_q, owner_d;
   logic [ID_W-1:0]            digest_id_q, digest_id_d;
   logic                       init_q, init_d;
   logic                       last_q, last_d;
   logic [SHA256_BLOCK_W-1:0]  block_q, block_d;
   logic [SHA256_DIGEST_W-1:0] digest_q, digest_d;

   logic                       pick_found;
   logic [ID_W-1:0]            pick_idx;
   logic [N_REQ-1:0]           req_ready_c;
   logic                       proto_err_c;
   logic                       core_start_c;
   logic                       digest_valid_c;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
      return (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
   endfunction

   sha256_rr_pick #(
      .N     (N_REQ),
      .IDX_W (ID_W)
   ) u_pick (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      owner_d        = owner_q;
      digest_id_d    = digest_id_q;
      init_d         = init_q;
      last_d         = last_q;
      block_d        = block_q;
      digest_d       = digest_q;
      req_ready_c    = '0;
      proto_err_c    = 1'b0;
      core_start_c   = 1'b0;
      digest_valid_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               req_ready_c[pick_idx] = 1'b1;
               if (bus.req_first[pick_idx]) begin
                  block_d = bus.req_block[pick_idx*SHA256_BLOCK_W +: SHA256_BLOCK_W];
                  init_d  = 1'b1;
                  last_d  = bus.req_last[pick_idx];
                  owner_d = pick_idx;
                  state_d = ST_ISSUE;
               end else begin
                  // A mid-message block with no owning message is dropped; move
                  // the pointer past it so the offender cannot starve others.
                  proto_err_c = 1'b1;
                  rr_ptr_d    = wrap_inc(pick_idx);
               end
            end
         end
         ST_ISSUE: begin
            if (bus.core_ready) begin
               core_start_c = 1'b1;
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.core_hash_valid) begin
               if (last_q) begin
                  digest_d    = bus.core_hash;
                  digest_id_d = owner_q;
                  state_d     = ST_DONE;
               end else begin
                  state_d = ST_NEXT;
               end
            end
         end
         ST_NEXT: begin
            // The lock is kept even when the owner restarts with a new first block.
            if (bus.req_valid[owner_q]) begin
               req_ready_c[owner_q] = 1'b1;
               proto_err_c          = bus.req_first[owner_q];
               init_d               = bus.req_first[owner_q];
               last_d               = bus.req_last[owner_q];
               block_d              = bus.req_block[owner_q*SHA256_BLOCK_W +: SHA256_BLOCK_W];
               state_d              = ST_ISSUE;
            end
         end
         ST_DONE: begin
            digest_valid_c = 1'b1;
            rr_ptr_d       = wrap_inc(owner_q);
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         digest_id_q <= '0;
         init_q      <= 1'b0;
         last_q      <= 1'b0;
         block_q     <= '0;
         digest_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         digest_id_q <= digest_id_d;
         init_q      <= init_d;
         last_q      <= last_d;
         block_q     <= block_d;
         digest_q    <= digest_d;
      end
   end

   // Accept pulses are combinational from req_valid, so mask them while reset is held.
   assign bus.req_ready    = reset ? '0 : req_ready_c;
   assign bus.proto_err    = reset ? 1'b0 : proto_err_c;
   assign bus.core_start   = core_start_c;
   assign bus.core_init    = init_q;
   assign bus.core_block   = block_q;
   assign bus.digest_out   = digest_q;
   assign bus.digest_valid = digest_valid_c;
   assign bus.digest_id    = digest_id_q;
   assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha256_msg_arbiter.sv
// Bench for sha256_msg_arbiter: queued requester blocks, a latency-programmable core
// model and a digest scoreboard checked against per-scenario expectations.
module tb_sha256_msg_arbiter;
   import sha256_pkg::*;

   localparam int N   = 4;
   localparam int IDW = 2;

   localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
   localparam logic [255:0] ABC_DIG =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   typedef struct { int id; logic [511:0] blk; bit first; bit last; } item_t;
   typedef struct { int id; logic [255:0] dig; } exp_t;
   typedef struct { int cyc; bit init; } start_t;
   typedef struct { int cyc; int id; } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sha256_msg_arbiter_if #(.N_REQ(N)) bus ();

   sha256_msg_arbiter #(.N_REQ(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   item_t  feed_q[$];
   exp_t   exp_q[$];
   start_t start_log[$];
   ev_t    ready_log[$];
   ev_t    dig_log[$];
   int     perr_log[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int multi_ready = 0;
   int start_no_rdy = 0;
   int core_lat = 8;
   bit core_rdy_en = 1'b1;
   bit stray_req = 1'b0;
   bit rdy_arm = 1'b0;
   int first_rdy_cyc = -1;

   bit           cm_busy = 1'b0;
   int           cm_cnt = 0;
   logic [255:0] cm_state = '0;
   logic [255:0] cm_result = '0;

   function automatic logic [255:0] core_fn(input bit init, input logic [255:0] prev,
                                            input logic [511:0] blk);
      logic [255:0] base;
      if (init && blk == ABC_BLK) return ABC_DIG;
      base = init ? IV : prev;
      return {base[254:0], base[255]} ^ blk[511:256] ^ blk[255:0] ^ 256'h5a5a;
   endfunction

   function automatic logic [511:0] mkblk(input int id, input int n);
      return {8'(id), 8'(n), {31{16'ha5c3}}};
   endfunction

   // Requester queues and core model; outputs sampled at negedge, inputs updated after posedge.
   initial begin
      logic [N-1:0] rdy;
      bit           fnd;
      exp_t         e;
      bus.req_valid       = '0;
      bus.req_block       = '0;
      bus.req_first       = '0;
      bus.req_last        = '0;
      bus.core_ready      = 1'b0;
      bus.core_hash_valid = 1'b0;
      bus.core_hash       = '0;
      forever begin
         @(negedge clk);
         rdy = bus.req_ready;
         if (!$onehot0(rdy)) multi_ready++;
         for (int i = 0; i < N; i++) if (rdy[i]) ready_log.push_back('{cyc, i});
         if (bus.proto_err) perr_log.push_back(cyc);
         if (rdy_arm && bus.core_ready) begin
            first_rdy_cyc = cyc;
            rdy_arm = 1'b0;
         end
         if (bus.core_start) begin
            if (!bus.core_ready) start_no_rdy++;
            start_log.push_back('{cyc, bus.core_init});
            cm_result = core_fn(bus.core_init, cm_state, bus.core_block);
            cm_state  = cm_result;
            cm_busy   = 1'b1;
            cm_cnt    = core_lat;
         end
         if (bus.digest_valid) begin
            dig_log.push_back('{cyc, int'(bus.digest_id)});
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL digest_unexpected: got id %0d digest %h, required no digest",
                        bus.digest_id, bus.digest_out);
            end else begin
               e = exp_q.pop_front();
               if (bus.digest_id !== IDW'(e.id) || bus.digest_out !== e.dig) begin
                  errors++;
                  $display("FAIL digest: got id %0d %h, required id %0d %h",
                           bus.digest_id, bus.digest_out, e.id, e.dig);
               end
            end
         end
         @(posedge clk);
         cyc++;
         #1;
         for (int i = 0; i < N; i++) begin
            if (rdy[i]) begin
               for (int k = 0; k < feed_q.size(); k++) begin
                  if (feed_q[k].id == i) begin
                     feed_q.delete(k);
                     break;
                  end
               end
            end
         end
         bus.core_hash_valid = 1'b0;
         if (cm_busy) begin
            cm_cnt--;
            if (cm_cnt <= 0) begin
               bus.core_hash_valid = 1'b1;
               bus.core_hash       = cm_result;
               cm_busy             = 1'b0;
            end
         end else if (stray_req) begin
            bus.core_hash_valid = 1'b1;
            bus.core_hash       = '1;
            stray_req           = 1'b0;
         end
         bus.core_ready = core_rdy_en && !cm_busy;
         for (int i = 0; i < N; i++) begin
            fnd = 1'b0;
            bus.req_valid[i] = 1'b0;
            bus.req_first[i] = 1'b0;
            bus.req_last[i]  = 1'b0;
            bus.req_block[i*512 +: 512] = '0;
            for (int k = 0; k < feed_q.size(); k++) begin
               if (!fnd && feed_q[k].id == i) begin
                  fnd = 1'b1;
                  bus.req_valid[i] = 1'b1;
                  bus.req_first[i] = feed_q[k].first;
                  bus.req_last[i]  = feed_q[k].last;
                  bus.req_block[i*512 +: 512] = feed_q[k].blk;
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_logs();
      start_log.delete();
      ready_log.delete();
      dig_log.delete();
      perr_log.delete();
   endtask

   task automatic push_item(input int id, input logic [511:0] blk, input bit first, input bit last);
      feed_q.push_back('{id, blk, first, last});
   endtask

   task automatic wait_sb(input int max, output int left);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < max) begin
         step(1);
         k++;
      end
      step(3);
      left = exp_q.size();
      exp_q.delete();
   endtask

   task automatic test_reset();
      step(3);
      checks++;
      if (bus.req_ready !== '0 || bus.proto_err !== 1'b0 || bus.core_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: got ready %b perr %b start %b, required 0 0 0",
                  bus.req_ready, bus.proto_err, bus.core_start);
      end
      checks++;
      if (bus.core_block !== '0 || bus.core_init !== 1'b0) begin
         errors++;
         $display("FAIL reset_core: got init %b block %h, required 0", bus.core_init, bus.core_block);
      end
      checks++;
      if (bus.digest_out !== '0 || bus.digest_valid !== 1'b0 || bus.digest_id !== '0) begin
         errors++;
         $display("FAIL reset_digest: got v %b id %0d %h, required all 0",
                  bus.digest_valid, bus.digest_id, bus.digest_out);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b, required 0", bus.busy);
      end
      reset = 1'b0;
      step(2);
   endtask

   task automatic test_fairness();
      int left;
      int exp_ids[5] = '{0, 1, 2, 3, 0};
      clear_logs();
      core_lat = 6;
      for (int i = 0; i < N; i++) push_item(i, mkblk(i, 0), 1'b1, 1'b1);
      push_item(0, mkblk(0, 1), 1'b1, 1'b1);
      for (int i = 0; i < N; i++) exp_q.push_back('{i, core_fn(1'b1, '0, mkblk(i, 0))});
      exp_q.push_back('{0, core_fn(1'b1, '0, mkblk(0, 1))});
      wait_sb(400, left);
      checks++;
      if (left !== 0) begin
         errors++;
         $display("FAIL fair_timeout: got %0d digests outstanding, required 0", left);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (k >= dig_log.size() || dig_log[k].id !== exp_ids[k]) begin
            errors++;
            $display("FAIL fair_order[%0d]: got id %0d, required %0d", k,
                     (k < dig_log.size()) ? dig_log[k].id : -1, exp_ids[k]);
         end
      end
   endtask

   task automatic test_single_block();
      int left;
      int t;
      clear_logs();
      core_lat = 64;
      push_item(2, ABC_BLK, 1'b1, 1'b1);
      exp_q.push_back('{2, ABC_DIG});
      wait_sb(300, left);
      checks++;
      if (left !== 0) begin
         errors++;
         $display("FAIL single_timeout: got %0d digests outstanding, required 0", left);
      end
      t = (ready_log.size() > 0) ? ready_log[0].cyc : -100;
      checks++;
      if (ready_log.size() !== 1 || ready_log[0].id !== 2) begin
         errors++;
         $display("FAIL single_ready: got %0d accepts, required 1 on req 2", ready_log.size());
      end
      checks++;
      if (start_log.size() !== 1 || start_log[0].cyc !== t + 1 || start_log[0].init !== 1'b1) begin
         errors++;
         $display("FAIL single_start: got %0d starts first at %0d, required 1 at %0d init 1",
                  start_log.size(), (start_log.size() > 0) ? start_log[0].cyc : -1, t + 1);
      end
      checks++;
      if (dig_log.size() !== 1 || dig_log[0].cyc !== t + 66 || dig_log[0].id !== 2) begin
         errors++;
         $display("FAIL single_latency: got %0d digests first at %0d, required 1 at %0d id 2",
                  dig_log.size(), (dig_log.size() > 0) ? dig_log[0].cyc : -1, t + 66);
      end
      checks++;
      if (bus.digest_out !== ABC_DIG || bus.digest_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: got v %b %h, required v 0 %h", bus.digest_valid, bus.digest_out, ABC_DIG);
      end
   endtask

   task automatic test_multi_block();
      int left;
      int r1;
      logic [255:0] h;
      bit exp_init[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      clear_logs();
      core_lat = 8;
      push_item(0, mkblk(0, 10), 1'b1, 1'b0);
      push_item(0, mkblk(0, 11), 1'b0, 1'b0);
      push_item(0, mkblk(0, 12), 1'b0, 1'b1);
      push_item(1, mkblk(1, 20), 1'b1, 1'b1);
      h = core_fn(1'b1, '0, mkblk(0, 10));
      h = core_fn(1'b0, h, mkblk(0, 11));
      h = core_fn(1'b0, h, mkblk(0, 12));
      exp_q.push_back('{0, h});
      exp_q.push_back('{1, core_fn(1'b1, '0, mkblk(1, 20))});
      wait_sb(300, left);
      checks++;
      if (left !== 0) begin
         errors++;
         $display("FAIL multi_timeout: got %0d digests outstanding, required 0", left);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= start_log.size() || start_log[k].init !== exp_init[k]) begin
            errors++;
            $display("FAIL multi_init[%0d]: got %0d starts, init %b, required init %b", k,
                     start_log.size(), (k < start_log.size()) ? start_log[k].init : 1'bx, exp_init[k]);
         end
      end
      r1 = -1;
      for (int k = ready_log.size() - 1; k >= 0; k--) if (ready_log[k].id == 1) r1 = ready_log[k].cyc;
      checks++;
      if (dig_log.size() < 1 || r1 <= dig_log[0].cyc) begin
         errors++;
         $display("FAIL multi_lock: got req1 accept at %0d, required after digest at %0d",
                  r1, (dig_log.size() > 0) ? dig_log[0].cyc : -1);
      end
   endtask

   task automatic test_proto_err();
      int left;
      clear_logs();
      core_lat = 8;
      push_item(3, mkblk(3, 30), 1'b0, 1'b1);
      step(10);
      checks++;
      if (perr_log.size() !== 1 || ready_log.size() !== 1 || ready_log[0].id !== 3 ||
          ready_log[0].cyc !== perr_log[0]) begin
         errors++;
         $display("FAIL perr_idle: got %0d errs %0d accepts, required 1 err with 1 accept on req 3",
                  perr_log.size(), ready_log.size());
      end
      checks++;
      if (start_log.size() !== 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL perr_idle_nostart: got %0d starts busy %b, required 0 starts busy 0",
                  start_log.size(), bus.busy);
      end
      clear_logs();
      push_item(1, mkblk(1, 40), 1'b1, 1'b0);
      push_item(1, mkblk(1, 41), 1'b1, 1'b1);
      exp_q.push_back('{1, core_fn(1'b1, '0, mkblk(1, 41))});
      wait_sb(300, left);
      checks++;
      if (left !== 0) begin
         errors++;
         $display("FAIL perr_next_timeout: got %0d digests outstanding, required 0", left);
      end
      checks++;
      if (perr_log.size() !== 1 || ready_log.size() !== 2 || ready_log[1].cyc !== perr_log[0]) begin
         errors++;
         $display("FAIL perr_next: got %0d errs %0d accepts, required 1 err on 2nd accept",
                  perr_log.size(), ready_log.size());
      end
      checks++;
      if (start_log.size() !== 2 || start_log[1].init !== 1'b1) begin
         errors++;
         $display("FAIL perr_restart_init: got %0d starts, required 2 with second init 1",
                  start_log.size());
      end
   endtask

   task automatic test_backpressure();
      int left;
      int k;
      clear_logs();
      core_lat = 8;
      core_rdy_en = 1'b0;
      push_item(2, mkblk(2, 50), 1'b1, 1'b1);
      exp_q.push_back('{2, core_fn(1'b1, '0, mkblk(2, 50))});
      k = 0;
      while (ready_log.size() == 0 && k < 20) begin
         step(1);
         k++;
      end
      checks++;
      if (ready_log.size() !== 1) begin
         errors++;
         $display("FAIL bp_accept: got %0d accepts, required 1", ready_log.size());
      end
      step(2);
      stray_req = 1'b1;
      step(8);
      rdy_arm = 1'b1;
      first_rdy_cyc = -1;
      core_rdy_en = 1'b1;
      wait_sb(200, left);
      checks++;
      if (left !== 0) begin
         errors++;
         $display("FAIL bp_timeout: got %0d digests outstanding, required 0", left);
      end
      checks++;
      if (start_log.size() !== 1 || start_log[0].cyc !== first_rdy_cyc || start_no_rdy !== 0) begin
         errors++;
         $display("FAIL bp_start: got %0d starts first at %0d (%0d w/o ready), required 1 at %0d",
                  start_log.size(), (start_log.size() > 0) ? start_log[0].cyc : -1,
                  start_no_rdy, first_rdy_cyc);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      clear_logs();
      core_lat = 64;
      push_item(0, mkblk(0, 60), 1'b1, 1'b1);
      k = 0;
      while (start_log.size() == 0 && k < 20) begin
         step(1);
         k++;
      end
      step(5);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.digest_valid !== 1'b0 || bus.core_block !== '0 ||
          bus.core_init !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: got busy %b dv %b init %b, required all 0",
                  bus.busy, bus.digest_valid, bus.core_init);
      end
      step(3);
      reset = 1'b0;
      step(80);
      checks++;
      if (dig_log.size() !== 0 || bus.busy !== 1'b0 || start_log.size() !== 1) begin
         errors++;
         $display("FAIL midreset_abandon: got %0d digests busy %b %0d starts, required 0 0 1",
                  dig_log.size(), bus.busy, start_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_fairness();
      test_single_block();
      test_multi_block();
      test_proto_err();
      test_backpressure();
      test_reset_mid();
      checks++;
      if (multi_ready !== 0) begin
         errors++;
         $display("FAIL ready_onehot: got %0d cycles with multiple accepts, required 0", multi_ready);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion by time %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sha256_msg_arbiter.md
Name: sha256_msg_arbiter

Overview:
- Shares one sha256_core between N requesters, each submitting a message as a sequence of preprocessed 512-bit blocks.
- Arbitrates round-robin at message granularity. Once granted, a requester keeps the core until its last block has been hashed.
- Sequences each block into the core, tells the core whether to load the IV or chain from the previous digest, and returns the final digest tagged with the requester id.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of requester id.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  requester i has a block on req_block slice i
- req_block  in  N_REQ*512  block i at bits [i*512 +: 512]
- req_first  in  N_REQ  block is the first of its message
- req_last  in  N_REQ  block is the last of its message (first and last may both be 1)
- req_ready  out  N_REQ  one-cycle accept pulse; block i is consumed that cycle
- core_start  out  1  one-cycle start pulse to the core
- core_init  out  1  valid with core_start; 1 = load IV, 0 = chain from current digest
- core_block  out  512  registered block for the core
- core_ready  in  1  core idle and able to accept start
- core_hash_valid  in  1  core finished the current block
- core_hash  in  256  core digest
- digest_out  out  256  final message digest
- digest_valid  out  1  one-cycle pulse
- digest_id  out  ID_W  requester owning digest_out
- proto_err  out  1  one-cycle pulse on a protocol violation (block dropped)
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, owner=0. All outputs are 0, including core_block, digest_out and digest_id.
- States: IDLE, ISSUE, WAIT, NEXT, DONE.
- IDLE:
  - Pick the first i with req_valid[i]=1, scanning from rr_ptr upward modulo N_REQ.
  - If req_first[i]=1: pulse req_ready[i], latch the block into core_block, latch init=1, last=req_last[i], owner=i, go to ISSUE.
  - If req_first[i]=0: pulse req_ready[i] and proto_err, drop the block, set rr_ptr=i+1, stay in IDLE.
- ISSUE:
  - While core_ready=0, hold.
  - On the first cycle with core_ready=1: core_start=1 and core_init=init, then go to WAIT.
- WAIT:
  - Hold until core_hash_valid=1.
  - On core_hash_valid: if last=1, capture core_hash into digest_out and go to DONE; otherwise go to NEXT.
- NEXT:
  - Only requester owner is considered; all other requesters see req_ready=0.
  - When req_valid[owner]=1 and req_first[owner]=0: pulse req_ready[owner], latch the block, init=0, last=req_last[owner], go to ISSUE.
  - When req_valid[owner]=1 and req_first[owner]=1: pulse req_ready[owner] and proto_err, then restart as a fresh message. Latch the block with init=1 and go to ISSUE. The lock is preserved.
- DONE: digest_valid=1 for one cycle with digest_id=owner; rr_ptr=owner+1 (wrapping N_REQ-1 to 0); go to IDLE.
- core_hash_valid outside WAIT is ignored.
- Latency, single-block message with core_ready=1: accept at cycle t, core_start at t+1, core_hash_valid at t+1+L, digest_valid one cycle later.
- The earliest new grant is the cycle after DONE, so there are no back-to-back grants in the same cycle.
- core_block, core_init and digest_out are stable between updates. digest_out holds until the next DONE.
- req_ready is never asserted to more than one requester in a cycle.
- Reset mid-operation: everything returns to reset values immediately. A partially hashed message is abandoned and no digest is emitted.

Decomposition:
- Package sha256_pkg holds:
  - SHA256_BLOCK_W=512 and SHA256_DIGEST_W=256;
  - the state enum typedef arb_state_t.
- Sub-module sha256_rr_pick: combinational round-robin priority picker. Inputs are req vector and ptr; outputs are found and index.

Test Plan:
- Reset: with reset=1 every output is 0. Hold reset high mid-WAIT, release, and confirm state=IDLE, busy=0 and no digest_valid.
- Single-block message on req 2 (first=last=1), core_ready=1, core L=64:
  - req_ready[2] at t;
  - core_start and core_init=1 at t+1;
  - digest_valid at t+66 with digest_id=2 and digest_out = core_hash for "abc" = ba7816bf...f20015ad.
- Three-block message on req 0 while req 1 holds valid:
  - core_init sequence is 1,0,0;
  - req_ready[1] stays 0 until after digest_valid (id 0);
  - req 1 is granted next.
- Fairness: all 4 requesters continuously valid with 1-block messages; digest_id order is 0,1,2,3,0 with rr_ptr wrapping 3 to 0.
- Protocol errors:
  - In IDLE, req 3 presents first=0: proto_err pulse, req_ready[3] pulse, no core_start.
  - In NEXT, the owner presents first=1: proto_err, then core_init=1 on the following core_start.
- Backpressure: core_ready=0 for 10 cycles in ISSUE. core_start is asserted exactly once, on the first cycle core_ready=1, and a stray core_hash_valid injected during ISSUE is ignored.
